// File: rtl/mem_fifo_pkg.sv
// Shared sizing for the 1R1W-memory-backed FIFO controller and its output buffer.
package mem_fifo_pkg;

  localparam int DEPTH         = 32;  // memory entries
  localparam int WIDTH         = 64;  // data bits per entry
  localparam int ADDR_W        = 5;   // log2(DEPTH)
  localparam int MASK_W        = 8;   // byte lanes
  localparam int OUT_BUF_DEPTH = 2;   // skid entries after the memory read port
  localparam int BUF_CNT_W     = 2;   // holds 0..OUT_BUF_DEPTH
  localparam int CNT_W         = 6;   // holds 0..DEPTH+OUT_BUF_DEPTH

endpackage

// File: rtl/mem_fifo_out_buf.sv
// Two-entry in-order output buffer; entry 0 is always the head word.
module mem_fifo_out_buf
  import mem_fifo_pkg::*;
#(
  parameter int DW = WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 push,
  input  logic [DW-1:0]        data_in,
  input  logic                 pop,
  output logic [DW-1:0]        head,
  output logic [BUF_CNT_W-1:0] cnt
);

  logic [DW-1:0]        entry_q [OUT_BUF_DEPTH];
  logic [DW-1:0]        entry_d [OUT_BUF_DEPTH];
  logic [BUF_CNT_W-1:0] cnt_q, cnt_d;

  // Next-state: push lands in the first free slot, pop shifts entry 1 down.
  always_comb begin
    entry_d = entry_q;
    cnt_d   = cnt_q;
    case ({push, pop})
      2'b10: begin
        entry_d[cnt_q[0]] = data_in;
        cnt_d             = cnt_q + BUF_CNT_W'(1);
      end
      2'b01: begin
        entry_d[0] = entry_q[1];
        cnt_d      = cnt_q - BUF_CNT_W'(1);
      end
      2'b11: begin
        // Simultaneous pop and push keeps the occupancy constant.
        if (cnt_q == BUF_CNT_W'(2)) begin
          entry_d[0] = entry_q[1];
          entry_d[1] = data_in;
        end else begin
          entry_d[0] = data_in;
        end
      end
      default: ;
    endcase
  end

  // Occupancy register; held words are discarded on reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Data entries need no reset; cnt_q qualifies them.
  always_ff @(posedge clock) begin
    entry_q <= entry_d;
  end

  assign head = entry_q[0];
  assign cnt  = cnt_q;

endmodule

// File: rtl/mem_1r1w_32x64_fifo_ctrl.sv
// FIFO controller around an external 1R1W masked memory with a 2-entry
// read-ahead buffer so the head word is registered and throughput is 1/cycle.
module mem_1r1w_32x64_fifo_ctrl #(
  parameter int DEPTH  = mem_fifo_pkg::DEPTH,
  parameter int WIDTH  = mem_fifo_pkg::WIDTH,
  parameter int ADDR_W = mem_fifo_pkg::ADDR_W,
  parameter int MASK_W = mem_fifo_pkg::MASK_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic                           enq_valid,
  output logic                           enq_ready,
  input  logic [WIDTH-1:0]               enq_data,
  output logic                           deq_valid,
  input  logic                           deq_ready,
  output logic [WIDTH-1:0]               deq_data,
  output logic [mem_fifo_pkg::CNT_W-1:0] count,
  output logic [ADDR_W-1:0]              W0_addr,
  output logic                           W0_en,
  output logic [WIDTH-1:0]               W0_data,
  output logic [MASK_W-1:0]              W0_mask,
  output logic [ADDR_W-1:0]              R0_addr,
  output logic                           R0_en,
  input  logic [WIDTH-1:0]               R0_data
);
  import mem_fifo_pkg::*;

  logic [ADDR_W-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     mem_cnt_q, mem_cnt_d;
  logic                 inflight_q, inflight_d;
  logic [BUF_CNT_W-1:0] buf_cnt;
  logic [BUF_CNT_W-1:0] buf_occupancy;
  logic [WIDTH-1:0]     buf_head;
  logic                 enq_fire;
  logic                 deq_fire;
  logic                 rd_issue;
  logic                 has_credit;
  logic                 buf_push;

  function automatic logic [ADDR_W-1:0] ptr_inc(input logic [ADDR_W-1:0] p);
    return (p == ADDR_W'(DEPTH - 1)) ? '0 : p + ADDR_W'(1);
  endfunction

  // enq_ready depends only on registered state, never on the consumer side.
  assign enq_ready = !reset && (mem_cnt_q < CNT_W'(DEPTH));
  assign deq_valid = !reset && (buf_cnt != '0);
  assign deq_data  = buf_head;
  assign enq_fire  = enq_valid & enq_ready;
  assign deq_fire  = deq_valid & deq_ready;

  // Credit exists while buffered plus in-flight words leave a free slot;
  // a pop this cycle frees one more, which keeps streaming at full rate.
  assign buf_occupancy = buf_cnt + BUF_CNT_W'(inflight_q);
  assign has_credit    = buf_occupancy < BUF_CNT_W'(OUT_BUF_DEPTH);
  assign rd_issue      = !reset && (mem_cnt_q != '0) && (has_credit || deq_fire);

  // Read data returns one cycle after issue; a read cancelled by reset is dropped.
  assign buf_push = inflight_q && !reset;

  assign W0_en   = enq_fire;
  assign W0_addr = wr_ptr_q;
  assign W0_data = enq_data;
  assign W0_mask = '1;
  assign R0_en   = rd_issue;
  assign R0_addr = rd_ptr_q;

  assign count = reset ? '0
                       : mem_cnt_q + CNT_W'(inflight_q) + CNT_W'(buf_cnt);

  // Pointer, memory occupancy and in-flight next-state.
  always_comb begin
    wr_ptr_d   = enq_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d   = rd_issue ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    mem_cnt_d  = mem_cnt_q;
    inflight_d = rd_issue;
    case ({enq_fire, rd_issue})
      2'b10:   mem_cnt_d = mem_cnt_q + CNT_W'(1);
      2'b01:   mem_cnt_d = mem_cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  // Control state registers; memory contents are left untouched by reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      mem_cnt_q  <= '0;
      inflight_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      mem_cnt_q  <= mem_cnt_d;
      inflight_q <= inflight_d;
    end
  end

  mem_fifo_out_buf #(
    .DW (WIDTH)
  ) u_out_buf (
    .clock   (clock),
    .reset   (reset),
    .push    (buf_push),
    .data_in (R0_data),
    .pop     (deq_fire),
    .head    (buf_head),
    .cnt     (buf_cnt)
  );

endmodule

// File: tb/tb_mem_1r1w_32x64_fifo_ctrl.sv
// Directed bench for the memory-backed FIFO controller with a behavioural 1R1W memory.
`timescale 1ns/1ps
module tb_mem_1r1w_32x64_fifo_ctrl;

  logic        clock = 1'b0;
  logic        reset;
  logic        enq_valid;
  logic        enq_ready;
  logic [63:0] enq_data;
  logic        deq_valid;
  logic        deq_ready;
  logic [63:0] deq_data;
  logic [5:0]  count;
  logic [4:0]  W0_addr;
  logic        W0_en;
  logic [63:0] W0_data;
  logic [7:0]  W0_mask;
  logic [4:0]  R0_addr;
  logic        R0_en;
  logic [63:0] R0_data;

  always #5 clock = ~clock;

  mem_1r1w_32x64_fifo_ctrl dut (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (enq_valid),
    .enq_ready (enq_ready),
    .enq_data  (enq_data),
    .deq_valid (deq_valid),
    .deq_ready (deq_ready),
    .deq_data  (deq_data),
    .count     (count),
    .W0_addr   (W0_addr),
    .W0_en     (W0_en),
    .W0_data   (W0_data),
    .W0_mask   (W0_mask),
    .R0_addr   (R0_addr),
    .R0_en     (R0_en),
    .R0_data   (R0_data)
  );

  // Behavioural masked 1R1W memory with registered read.
  logic [63:0] mem_model [32];
  always_ff @(posedge clock) begin
    if (W0_en) begin
      for (int b = 0; b < 8; b++) begin
        if (W0_mask[b]) mem_model[W0_addr][8*b +: 8] <= W0_data[8*b +: 8];
      end
    end
    if (R0_en) R0_data <= mem_model[R0_addr];
  end

  logic [63:0] sb [$];
  int          errors = 0;
  int          checks = 0;
  int          w_pulses = 0;
  int          r_pulses = 0;
  int          accepted = 0;
  int          dequeued = 0;
  logic [4:0]  exp_wa = '0;
  logic [4:0]  exp_ra = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic rst, input logic ev, input logic [63:0] ed, input logic dr);
    reset     = rst;
    enq_valid = ev;
    enq_data  = ed;
    deq_ready = dr;
    #1;
  endtask

  // Record this cycle's transactions, check addresses and scoreboard, then wait for the next cycle.
  task automatic adv();
    logic [63:0] exp_word;
    if (W0_en) begin
      w_pulses++;
      chk("w0_addr", 64'(W0_addr), 64'(exp_wa));
      chk("w0_mask", 64'(W0_mask), 64'(8'hFF));
      exp_wa = exp_wa + 5'd1;
    end
    chk("w0_en", 64'(W0_en), 64'(enq_valid && enq_ready));
    if (enq_valid && enq_ready) begin
      sb.push_back(enq_data);
      accepted++;
      $display("enq 0x%016h", enq_data);
    end
    if (R0_en) begin
      r_pulses++;
      chk("r0_addr", 64'(R0_addr), 64'(exp_ra));
      exp_ra = exp_ra + 5'd1;
    end
    if (deq_valid && deq_ready) begin
      dequeued++;
      $display("deq 0x%016h", deq_data);
      checks++;
      assert (sb.size() > 0) else begin
        errors++;
        $error("FAIL deq_unexpected observed=0x%0h expected=none", deq_data);
      end
      if (sb.size() > 0) begin
        exp_word = sb.pop_front();
        chk("deq_data", deq_data, exp_word);
      end
    end
    @(negedge clock);
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (count != 6'd0 && n < 200) begin
      drive(1'b0, 1'b0, 64'd0, 1'b1);
      adv();
      n++;
    end
    chk({tag, "_count"}, 64'(count), 64'd0);
    chk({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    int wb;
    int rb;
    int sent;
    int cyc;

    reset = 1'b1; enq_valid = 1'b0; enq_data = '0; deq_ready = 1'b0;
    @(negedge clock);

    // Reset holds every output quiet even with requests present.
    drive(1'b1, 1'b1, 64'hAA, 1'b1);
    chk("rst_enq_ready", 64'(enq_ready), 64'd0);
    chk("rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_w0_en",     64'(W0_en),     64'd0);
    chk("rst_r0_en",     64'(R0_en),     64'd0);
    adv();

    // Single word: 3-cycle latency, count 1 in cycles 1-3.
    drive(1'b0, 1'b1, 64'hDEADBEEF_00000001, 1'b1);
    chk("t1_c0_count", 64'(count), 64'd0);
    chk("t1_c0_enq_ready", 64'(enq_ready), 64'd1);
    adv();
    for (int c = 1; c <= 3; c++) begin
      drive(1'b0, 1'b0, 64'd0, 1'b1);
      chk("t1_count", 64'(count), 64'd1);
      chk("t1_deq_valid", 64'(deq_valid), 64'(c == 3));
      adv();
    end
    drive(1'b0, 1'b0, 64'd0, 1'b1);
    chk("t1_c4_count", 64'(count), 64'd0);
    chk("t1_c4_deq_valid", 64'(deq_valid), 64'd0);
    adv();

    // Fill: 40 offered, 34 accepted, two reads run ahead into the buffer.
    base = accepted; wb = w_pulses; rb = r_pulses;
    for (int i = 0; i < 40; i++) begin
      drive(1'b0, 1'b1, 64'h1000 + 64'(i), 1'b0);
      chk("fill_count", 64'(count), 64'(accepted - base));
      chk("fill_enq_ready", 64'(enq_ready), 64'((accepted - base) < 34));
      adv();
    end
    chk("fill_accepted", 64'(accepted - base), 64'd34);
    chk("fill_w0_pulses", 64'(w_pulses - wb), 64'd34);
    chk("fill_r0_pulses", 64'(r_pulses - rb), 64'd2);

    // Backpressure release: one pop issues a read in the same cycle.
    drive(1'b0, 1'b0, 64'd0, 1'b1);
    chk("bp_deq_valid", 64'(deq_valid), 64'd1);
    chk("bp_r0_en", 64'(R0_en), 64'd1);
    chk("bp_enq_ready", 64'(enq_ready), 64'd0);
    chk("bp_count", 64'(count), 64'd34);
    adv();
    drive(1'b0, 1'b0, 64'd0, 1'b0);
    chk("bp_enq_ready_next", 64'(enq_ready), 64'd1);
    chk("bp_count_next", 64'(count), 64'd33);
    adv();
    drain("bp_drain");

    // Streaming at one word per cycle; count settles at 3.
    for (int i = 0; i < 100; i++) begin
      drive(1'b0, 1'b1, 64'h2000_0000 + 64'(i), 1'b1);
      chk("stream_count", 64'(count), 64'((i < 3) ? i : 3));
      chk("stream_deq_valid", 64'(deq_valid), 64'(i >= 3));
      chk("stream_enq_ready", 64'(enq_ready), 64'd1);
      adv();
    end
    drain("stream_drain");

    // Wrap: 70 words against random consumer stalls.
    base = accepted; sent = 0; cyc = 0;
    while (sent < 70 && cyc < 2000) begin
      drive(1'b0, 1'b1, 64'h3000 + 64'(sent), 1'($urandom_range(0, 1)));
      adv();
      sent = accepted - base;
      cyc++;
    end
    chk("wrap_sent", 64'(sent), 64'd70);
    drain("wrap_drain");

    // Mid-operation reset with 10 held words and a read in flight.
    for (int i = 0; i < 11; i++) begin
      drive(1'b0, 1'b1, 64'h4000 + 64'(i), 1'b0);
      adv();
    end
    drive(1'b0, 1'b0, 64'd0, 1'b0); adv();
    drive(1'b0, 1'b0, 64'd0, 1'b0); adv();
    drive(1'b0, 1'b0, 64'd0, 1'b1);
    chk("mr_deq_valid", 64'(deq_valid), 64'd1);
    chk("mr_r0_en", 64'(R0_en), 64'd1);
    adv();
    chk("mr_held", 64'(count), 64'd10);
    drive(1'b1, 1'b1, 64'h77, 1'b1);
    chk("mr_rst_enq_ready", 64'(enq_ready), 64'd0);
    chk("mr_rst_deq_valid", 64'(deq_valid), 64'd0);
    chk("mr_rst_count", 64'(count), 64'd0);
    chk("mr_rst_w0_en", 64'(W0_en), 64'd0);
    chk("mr_rst_r0_en", 64'(R0_en), 64'd0);
    adv();
    sb.delete();
    exp_wa = '0;
    exp_ra = '0;
    drive(1'b0, 1'b0, 64'd0, 1'b1);
    chk("mr_post_count", 64'(count), 64'd0);
    chk("mr_post_deq_valid", 64'(deq_valid), 64'd0);
    adv();
    base = dequeued;
    drive(1'b0, 1'b1, 64'h5, 1'b1);
    adv();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, 1'b0, 64'd0, 1'b1);
      adv();
    end
    chk("mr_deq_total", 64'(dequeued - base), 64'd1);
    chk("mr_sb_empty", 64'(sb.size()), 64'd0);
    chk("mr_final_count", 64'(count), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
